// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - two-way set-associative write-through read cache in front of the SRAM controller
module sram_cache_controller #(
  parameter int BASE_ADDR  = 1024,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int          NUM_SETS = 1 << INDEX_BITS;
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state, next_state;

  logic                  valid0 [NUM_SETS];
  logic                  valid1 [NUM_SETS];
  logic [TAG_BITS-1:0]   tag0   [NUM_SETS];
  logic [TAG_BITS-1:0]   tag1   [NUM_SETS];
  logic [63:0]           data0  [NUM_SETS];
  logic [63:0]           data1  [NUM_SETS];
  logic                  lru    [NUM_SETS];

  logic [31:0]           off;
  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit0, hit1, hit;
  logic [63:0]           hit_line;
  logic [31:0]           hit_word;
  logic [31:0]           fill_word;

  // Address decode relative to the SRAM window and hit lookup in both ways
  always_comb begin
    off       = address - BASE;
    word_sel  = off[2];
    index     = off[3 +: INDEX_BITS];
    tag       = off[3 + INDEX_BITS +: TAG_BITS];
    hit0      = valid0[index] && (tag0[index] == tag);
    hit1      = valid1[index] && (tag1[index] == tag);
    hit       = hit0 || hit1;
    hit_line  = hit0 ? data0[index] : data1[index];
    hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
    fill_word = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; writes win over reads when both are requested
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_en)             next_state = WRITE;
        else if (rd_en && !hit) next_state = READ_MISS;
      end
      READ_MISS: if (sram_ready) next_state = IDLE;
      WRITE:     if (sram_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode: SRAM side from state, hit data combinational in IDLE
  always_comb begin
    ready           = 1'b1;
    read_data       = 32'h0;
    sram_wr_en      = 1'b0;
    sram_rd_en      = 1'b0;
    sram_address    = 32'h0;
    sram_write_data = 32'h0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          ready = 1'b0;
        end else if (rd_en) begin
          ready = hit;
          if (hit) read_data = hit_word;
        end
      end
      READ_MISS: begin
        sram_rd_en   = 1'b1;
        sram_address = address;
        ready        = sram_ready;
        if (sram_ready) read_data = fill_word;
      end
      WRITE: begin
        sram_wr_en      = 1'b1;
        sram_address    = address;
        sram_write_data = write_data;
        ready           = sram_ready;
      end
      default: ready = 1'b1;
    endcase
  end

  // Valid/LRU bookkeeping, write-hit update and miss fill
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        valid0[i] <= 1'b0;
        valid1[i] <= 1'b0;
        lru[i]    <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && hit) begin
            if (hit0) begin
              if (word_sel) data0[index][63:32] <= write_data;
              else          data0[index][31:0]  <= write_data;
            end else begin
              if (word_sel) data1[index][63:32] <= write_data;
              else          data1[index][31:0]  <= write_data;
            end
            lru[index] <= hit0;
          end else if (!wr_en && rd_en && hit) begin
            lru[index] <= hit0;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            if (lru[index]) begin
              valid1[index] <= 1'b1;
              tag1[index]   <= tag;
              data1[index]  <= sram_read_data;
            end else begin
              valid0[index] <= 1'b1;
              tag0[index]   <= tag;
              data0[index]  <= sram_read_data;
            end
            lru[index] <= ~lru[index];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
